// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder with valid/ready operand and result handshakes
// Optional signed-overflow flag and per-bit debug print: define SERIAL_ADDER_OVF_EN
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_sh;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic sum_bit;
   logic carry_next;
   logic last_bit;
   logic accept;

   // One full-adder cell feeding the registered carry.
   assign sum_bit    = a_sh[0] ^ b_sh[0] ^ carry;
   assign carry_next = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
   assign last_bit   = (cnt == LAST);
   assign accept     = (state == IDLE) && in_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid)  state_next = RUN;
         RUN:     if (last_bit)  state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default:                state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh   <= '0;
         b_sh   <= '0;
         sum_sh <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
      end else if (accept) begin
         a_sh  <= a;
         b_sh  <= b;
         carry <= cin;
         cnt   <= '0;
      end else if (state == RUN) begin
         a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
         b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
         sum_sh <= {sum_bit, sum_sh[WIDTH-1:1]};
         carry  <= carry_next;
         cnt    <= cnt + 1'b1;
      end
   end

   assign in_ready  = (state == IDLE);
   assign busy      = (state == RUN);
   assign out_valid = (state == DONE);
   assign sum       = sum_sh;
   assign cout      = carry;

`ifdef SERIAL_ADDER_OVF_EN
   logic ovf_q;

   // Signed overflow: carry into the MSB differs from carry out of it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if ((state == RUN) && last_bit) begin
         ovf_q <= carry ^ carry_next;
      end
   end

   always_ff @(posedge clk) begin
      if (state == RUN) begin
         $display("serial_adder bit=%0d sum_bit=%0b carry=%0b", cnt, sum_bit, carry);
      end
   end

   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder against an arithmetic reference model
module tb_serial_adder;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             busy;

   int checks;
   int failures;

   serial_adder #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [WIDTH:0] model_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                                input logic c);
      int unsigned s;
      s = int'(x) + int'(y) + int'(c);
      return s[WIDTH:0];
   endfunction

   function automatic logic model_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                      input logic c);
`ifdef SERIAL_ADDER_OVF_EN
      int s;
      s = int'($signed(x)) + int'($signed(y)) + int'(c);
      return (s > (2 ** (WIDTH - 1)) - 1) || (s < -(2 ** (WIDTH - 1)));
`else
      return 1'b0;
`endif
   endfunction

   // Drives one transaction from IDLE; returns what was observed, the tests judge it.
   task automatic run_txn(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_op, input logic tc,
                          input int hold, input logic pre_ready,
                          output int lat, output logic busy_ok, output logic [WIDTH-1:0] got_sum,
                          output logic got_cout, output logic got_ovf, output logic stable_ok,
                          output logic idle_ok);
      a = ta; b = tb_op; cin = tc; in_valid = 1'b1; out_ready = pre_ready;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = $urandom; b = $urandom; cin = $urandom;
      lat = 0;
      busy_ok = 1'b1;
      while (!out_valid && lat < 4 * WIDTH) begin
         if (!busy || in_ready) busy_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      got_sum = sum; got_cout = cout; got_ovf = ovf;
      stable_ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         if (sum !== got_sum || cout !== got_cout || ovf !== got_ovf || !out_valid || in_ready)
            stable_ok = 1'b0;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      idle_ok = in_ready && !out_valid && !busy;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      checks++;
      if ({in_ready, out_valid, busy, sum, cout, ovf} !== {1'b1, 1'b0, 1'b0, {WIDTH{1'b0}}, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL reset: in_ready=%0b out_valid=%0b busy=%0b sum=%h cout=%0b ovf=%0b required 1 0 0 00 0 0",
                  in_ready, out_valid, busy, sum, cout, ovf);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_directed(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_op, input logic tc,
                                input string name);
      int lat; logic bok, gc, go, sok, iok; logic [WIDTH-1:0] gs; logic [WIDTH:0] exp;
      exp = model_add(ta, tb_op, tc);
      run_txn(ta, tb_op, tc, 0, 1'b0, lat, bok, gs, gc, go, sok, iok);
      checks++;
      if (lat !== WIDTH || !bok) begin
         failures++;
         $display("FAIL %s latency: edges=%0d busy_ok=%0b required %0d 1", name, lat, bok, WIDTH);
      end
      checks++;
      if ({gc, gs} !== exp) begin
         failures++;
         $display("FAIL %s sum: cout=%0b sum=%h required cout=%0b sum=%h", name, gc, gs, exp[WIDTH], exp[WIDTH-1:0]);
      end
      checks++;
      if (go !== model_ovf(ta, tb_op, tc)) begin
         failures++;
         $display("FAIL %s ovf: got %0b required %0b", name, go, model_ovf(ta, tb_op, tc));
      end
      checks++;
      if (!iok) begin
         failures++;
         $display("FAIL %s release: in_ready=%0b out_valid=%0b required 1 0", name, in_ready, out_valid);
      end
   endtask

   task automatic test_random();
      int lat; logic bok, gc, go, sok, iok; logic [WIDTH-1:0] gs, ra, rb; logic rc, pr; int hold;
      logic [WIDTH:0] exp;
      for (int n = 0; n < 25; n++) begin
         ra = $urandom; rb = $urandom; rc = $urandom; pr = $urandom;
         hold = pr ? 0 : $urandom_range(0, 3);
         exp = model_add(ra, rb, rc);
         run_txn(ra, rb, rc, hold, pr, lat, bok, gs, gc, go, sok, iok);
         checks++;
         if ({gc, gs} !== exp || go !== model_ovf(ra, rb, rc) || lat !== WIDTH || !bok || !sok || !iok) begin
            failures++;
            $display("FAIL random %h+%h+%0b: cout=%0b sum=%h ovf=%0b lat=%0d busy_ok=%0b stable=%0b idle=%0b required cout=%0b sum=%h ovf=%0b lat=%0d 1 1 1",
                     ra, rb, rc, gc, gs, go, lat, bok, sok, iok, exp[WIDTH], exp[WIDTH-1:0],
                     model_ovf(ra, rb, rc), WIDTH);
         end
      end
   endtask

   task automatic test_backpressure();
      int lat; logic [WIDTH-1:0] held_sum; logic held_cout; logic ok; logic [WIDTH:0] exp;
      exp = model_add(8'h11, 8'h05, 1'b0);
      a = 8'h11; b = 8'h05; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      lat = 0;
      while (!out_valid && lat < 4 * WIDTH) begin
         @(posedge clk); #1;
         lat++;
      end
      held_sum = sum; held_cout = cout;
      checks++;
      if ({held_cout, held_sum} !== exp || lat !== WIDTH) begin
         failures++;
         $display("FAIL backpressure first result: cout=%0b sum=%h lat=%0d required cout=%0b sum=%h lat=%0d",
                  held_cout, held_sum, lat, exp[WIDTH], exp[WIDTH-1:0], WIDTH);
      end
      ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (sum !== held_sum || cout !== held_cout || in_ready !== 1'b0 || out_valid !== 1'b1) ok = 1'b0;
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL backpressure hold: sum=%h cout=%0b in_ready=%0b out_valid=%0b required sum=%h cout=%0b 0 1",
                  sum, cout, in_ready, out_valid, held_sum, held_cout);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL backpressure release: in_ready=%0b out_valid=%0b required 1 0", in_ready, out_valid);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL backpressure reaccept: busy=%0b required 1", busy);
      end
      lat = 0;
      while (!out_valid && lat < 4 * WIDTH) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if ({cout, sum} !== exp || lat !== WIDTH) begin
         failures++;
         $display("FAIL backpressure second result: cout=%0b sum=%h lat=%0d required cout=%0b sum=%h lat=%0d",
                  cout, sum, lat, exp[WIDTH], exp[WIDTH-1:0], WIDTH);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      logic saw_valid;
      a = 8'hAA; b = 8'h55; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({in_ready, out_valid, busy, sum, cout, ovf} !== {1'b1, 1'b0, 1'b0, {WIDTH{1'b0}}, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL mid-run reset: in_ready=%0b out_valid=%0b busy=%0b sum=%h cout=%0b ovf=%0b required 1 0 0 00 0 0",
                  in_ready, out_valid, busy, sum, cout, ovf);
      end
      saw_valid = 1'b0;
      for (int i = 0; i < 2 * WIDTH; i++) begin
         @(posedge clk); #1;
         if (out_valid) saw_valid = 1'b1;
      end
      checks++;
      if (saw_valid) begin
         failures++;
         $display("FAIL mid-run reset pulse: out_valid seen=%0b required 0", saw_valid);
      end
      out_ready = 1'b0;
      rst_n = 1'b1;
      test_directed(8'h0F, 8'h01, 1'b0, "after_reset");
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_directed(8'h35, 8'h1A, 1'b0, "basic");
      test_directed(8'hFF, 8'h01, 1'b0, "wrap");
      test_directed(8'h00, 8'h00, 1'b1, "cin_only");
      test_directed(8'h7F, 8'h01, 1'b0, "ovf_pos");
      test_directed(8'h80, 8'h80, 1'b0, "ovf_neg");
      test_backpressure();
      test_random();
      test_reset_mid_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder built around the team's 1-bit full-adder cell, plus a registered carry flip-flop.
- Accepts one operand pair per transaction over a valid/ready handshake and shifts the operands through the adder LSB first, one bit per clock.
- Returns the N-bit sum and carry-out over a second valid/ready handshake.
- Sits downstream of operand sources and upstream of any result consumer. It is the sequential stage that consumes the full-adder cell's s/cout every cycle.

Parameters:
WIDTH, 8, operand and sum width in bits (legal range 2..32)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  operand pair a/b/cin is valid
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  WIDTH  operand A, unsigned or two's complement
b  input  WIDTH  operand B
cin  input  1  initial carry-in
out_valid  output  1  sum/cout/ovf are valid
out_ready  input  1  consumer accepts the result
sum  output  WIDTH  a+b+cin modulo 2^WIDTH
cout  output  1  carry out of bit WIDTH-1
ovf  output  1  signed overflow (see Optional Feature)
busy  output  1  high in RUN

Behaviour:
- Clock and reset:
  - Single clock domain.
  - rst_n low immediately forces state IDLE, clears the operand shift registers, the sum shift register, the carry flip-flop and the bit counter, and drives sum=0, cout=0, ovf=0, out_valid=0, busy=0, in_ready=1. The reset value of in_ready is 1.
- State machine: states IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid&&in_ready: load a and b into the shift registers, load carry<=cin, set counter<=0, go to RUN.
- RUN:
  - in_ready=0, busy=1.
  - Each edge: sum_bit = a_sh[0]^b_sh[0]^carry; carry <= majority(a_sh[0], b_sh[0], carry).
  - sum_sh shifts right with sum_bit entering at MSB; a_sh and b_sh shift right.
  - counter increments.
  - On the edge where counter==WIDTH-1, go to DONE.
  - Latency: out_valid rises exactly WIDTH clock edges after the accepting edge.
  - in_valid is ignored during RUN.
- DONE:
  - out_valid=1.
  - sum=sum_sh and cout=carry, both held stable until an edge with out_valid&&out_ready.
  - On that edge: go to IDLE, out_valid<=0.
  - in_ready returns to 1 on the following cycle. There is no same-cycle accept/complete overlap.
  - If out_ready is already high when DONE is entered, the result is held for exactly one cycle.
- Outputs sum/cout/ovf are only meaningful while out_valid=1. They hold their last values in IDLE until the next accept.
- Wrap-around: the carry out of the MSB appears only on cout. sum never exceeds WIDTH bits.
- Reset mid-RUN or mid-DONE: the operation is aborted and no out_valid pulse is produced. The next transaction after reset release behaves normally.
- A simultaneous in_valid and reset release is not accepted until the first edge after rst_n is high.

Optional Feature:
SERIAL_ADDER_OVF_EN
- Defined:
  - During the last RUN bit, register ovf <= carry_into_msb ^ carry_out_msb.
  - ovf is valid with out_valid and held like sum.
  - Every RUN cycle, also print bit index, sum_bit and carry via $display for debug.
- Undefined:
  - ovf is tied to 0 and there is no display output.
  - The port list is identical in both builds.

Test Plan:
1. Assert rst_n=0 for 3 cycles, then release -> in_ready=1, out_valid=0, busy=0, sum=8'h00, cout=0.
2. WIDTH=8; a=8'h35, b=8'h1A, cin=0 accepted at edge E0 -> busy high for 8 cycles; out_valid=1 after edge E8 with sum=8'h4F, cout=0.
3. a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0. Then a=8'h00, b=8'h00, cin=1 -> sum=8'h01, cout=0.
4. With SERIAL_ADDER_OVF_EN: a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, ovf=1. a=8'h80, b=8'h80 -> sum=8'h00, cout=1, ovf=1. Without the macro, ovf=0 in both cases.
5. Backpressure:
   - Stimulus: out_ready=0 for 5 cycles after out_valid rises; in_valid=1 with a=8'h11 throughout.
   - Required: sum/cout stable and in_ready=0; the pending operands are not accepted.
   - Then raise out_ready -> IDLE next edge, then a=8'h11 accepted.
6. Pull rst_n low after the 3rd RUN bit of a=8'hAA+b=8'h55 -> immediate IDLE with all outputs at reset values and no out_valid. After release, a=8'h0F+b=8'h01 -> sum=8'h10, cout=0.
